vga_rx: RTL and testbench

VGA_RX -- requirements
Module: vga_rx

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_rx_if.sv | 28 ++
 rtl/vga_rx_sync_det.sv | 41 ++++
 rtl/vga_rx.sv | 169 ++++++++++++++++
 tb/tb_vga_rx.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and FSM state encoding used by the capture path
// and the existing VGA controller.
package vga_pkg;

  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int H_START  = 144;
  localparam int V_START  = 35;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } vga_state_e;

endpackage

// File: rtl/vga_rx_if.sv
// Video-in / frame-buffer-write bundle of the VGA receiver. The receiver
// takes the slave view; the video source and buffer sink take the master view.
interface vga_rx_if;

  logic        hs;
  logic        vs;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        wen;
  logic [8:0]  wr_row;
  logic [9:0]  wr_col;
  logic [11:0] wr_data;
  logic        locked;
  logic        frame_done;
  logic        err;

  modport master (
    output hs, vs, r, g, b,
    input  wen, wr_row, wr_col, wr_data, locked, frame_done, err
  );

  modport slave (
    input  hs, vs, r, g, b,
    output wen, wr_row, wr_col, wr_data, locked, frame_done, err
  );

endinterface

// File: rtl/vga_rx_sync_det.sv
// Input register stage of the VGA receiver: registers syncs and colour once
// and flags falling edges of the registered active-low syncs.
module vga_rx_sync_det (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        hs_fall,
  output logic        vs_fall,
  output logic [11:0] rgb
);

  logic        hs_q, hs_prev_q;
  logic        vs_q, vs_prev_q;
  logic [11:0] rgb_q;

  // History clears to low so no edge can be reported until a sync is seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hs_q      <= hs;
      hs_prev_q <= hs_q;
      vs_q      <= vs;
      vs_prev_q <= vs_q;
      rgb_q     <= {r, g, b};
    end
  end

  assign hs_fall = hs_prev_q & ~hs_q;
  assign vs_fall = vs_prev_q & ~vs_q;
  assign rgb     = rgb_q;

endmodule

// File: rtl/vga_rx.sv
// VGA capture: locks onto an hs/vs/rgb stream and writes active pixels into a
// frame buffer. Define VGA_RX_DECIMATE_EN to write a 2:1 decimated image.
module vga_rx #(
  parameter int H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int H_START  = vga_pkg::H_START,
  parameter int V_START  = vga_pkg::V_START,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
  input logic     clk,
  input logic     rst,
  vga_rx_if.slave vid
);

  import vga_pkg::*;

  localparam logic [9:0] HTOT  = 10'(H_TOTAL);
  localparam logic [9:0] VTOT  = 10'(V_TOTAL);
  localparam logic [9:0] VLAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HBEG  = 10'(H_START);
  localparam logic [9:0] HEND  = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] VBEG  = 10'(V_START);
  localparam logic [9:0] VEND  = 10'(V_START + V_ACTIVE);

  logic        hs_fall, vs_fall;
  logic [11:0] rgb;

  vga_rx_sync_det u_sync (
    .clk     (clk),
    .rst     (rst),
    .hs      (vid.hs),
    .vs      (vid.vs),
    .r       (vid.r),
    .g       (vid.g),
    .b       (vid.b),
    .hs_fall (hs_fall),
    .vs_fall (vs_fall),
    .rgb     (rgb)
  );

  // hcnt_q holds the count for the following cycle, so hcnt is 0 on the
  // edge cycle itself and hcnt_q equals the finished line length there.
  logic [9:0] hcnt_q, hcnt_d, hcnt;
  logic [9:0] lcnt_q, lcnt;
  logic       vs_pend_q, vs_pend_d;
  logic       line0;

  always_comb begin
    line0  = hs_fall & (vs_fall | vs_pend_q);
    hcnt   = hs_fall ? '0 : hcnt_q;
    hcnt_d = (hcnt == '1) ? hcnt : hcnt + 10'd1;
    lcnt   = lcnt_q;
    if (line0)                        lcnt = '0;
    else if (hs_fall && lcnt_q != '1) lcnt = lcnt_q + 10'd1;
    vs_pend_d = vs_pend_q;
    if (line0)        vs_pend_d = 1'b0;
    else if (vs_fall) vs_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q    <= '0;
      lcnt_q    <= '0;
      vs_pend_q <= 1'b0;
    end else begin
      hcnt_q    <= hcnt_d;
      lcnt_q    <= lcnt;
      vs_pend_q <= vs_pend_d;
    end
  end

  vga_state_e state_q, state_d;
  logic       meas_ok_q, meas_ok_d;
  logic       len_bad, frame_bad, err_cond;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      meas_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      meas_ok_q <= meas_ok_d;
    end
  end

  // Frame line count is lcnt_q + 1 whether vs falls with hs or mid-line.
  always_comb begin : next_state
    len_bad   = hs_fall ? (hcnt_q != HTOT) : (hcnt_q == HTOT);
    frame_bad = (vs_fall && (lcnt_q != VLAST)) || (lcnt >= VTOT);
    state_d   = state_q;
    meas_ok_d = meas_ok_q;
    unique case (state_q)
      IDLE: begin
        if (line0) begin
          state_d   = MEASURE;
          meas_ok_d = 1'b1;
        end
      end
      MEASURE: begin
        if (line0)
          state_d = (meas_ok_q && !len_bad && (lcnt_q == VLAST)) ? LOCKED : IDLE;
        else if (len_bad || (lcnt >= VTOT))
          meas_ok_d = 1'b0;
      end
      LOCKED: begin
        if (len_bad || frame_bad) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic       active, wr_ok, wen_d, done_d;
  logic [9:0] col_off, col_d;
  logic [8:0] row_off, row_d;

  always_comb begin : outputs
    err_cond = (state_q == LOCKED) && (len_bad || frame_bad);
    active   = (state_q == LOCKED) && (hcnt >= HBEG) && (hcnt < HEND) &&
               (lcnt >= VBEG) && (lcnt < VEND);
    wr_ok    = active && !err_cond;
    col_off  = hcnt - HBEG;
    row_off  = 9'(lcnt - VBEG);
`ifdef VGA_RX_DECIMATE_EN
    wen_d    = wr_ok && !col_off[0] && !row_off[0];
    col_d    = {1'b0, col_off[9:1]};
    row_d    = {1'b0, row_off[8:1]};
`else
    wen_d    = wr_ok;
    col_d    = col_off;
    row_d    = row_off;
`endif
    done_d   = wr_ok && (hcnt == HEND - 10'd1) && (lcnt == VEND - 10'd1);
  end

  logic        wen_q, done_q, err_q;
  logic [8:0]  row_q;
  logic [9:0]  col_q;
  logic [11:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      row_q  <= '0;
      col_q  <= '0;
      data_q <= '0;
    end else begin
      wen_q  <= wen_d;
      done_q <= done_d;
      err_q  <= err_cond;
      if (wen_d) begin
        row_q  <= row_d;
        col_q  <= col_d;
        data_q <= rgb;
      end
    end
  end

  assign vid.wen        = wen_q;
  assign vid.wr_row     = row_q;
  assign vid.wr_col     = col_q;
  assign vid.wr_data    = data_q;
  assign vid.frame_done = done_q;
  assign vid.err        = err_q;
  assign vid.locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_vga_rx.sv
// Directed bench for vga_rx on a reduced 40x20 raster (24x12 active) so that
// full frames stay short; expectations are derived from the raster geometry.
module tb_vga_rx;

  localparam int HT = 40;
  localparam int VT = 20;
  localparam int HS0 = 8;
  localparam int VS0 = 4;
  localparam int HA = 24;
  localparam int VA = 12;
`ifdef VGA_RX_DECIMATE_EN
  localparam int DEC = 2;
`else
  localparam int DEC = 1;
`endif
  localparam int FRAME_W = (HA / DEC) * (VA / DEC);

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_rx_if vid ();

  vga_rx #(
    .H_TOTAL  (HT),
    .V_TOTAL  (VT),
    .H_START  (HS0),
    .V_START  (VS0),
    .H_ACTIVE (HA),
    .V_ACTIVE (VA)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vid (vid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] pix(input int l, input int h);
    logic [11:0] v;
    if (l == VS0 && h == HS0) v = 12'hABC;
    else                      v = {6'(l), 6'(h)};
    return v;
  endfunction

  function automatic logic [11:0] exp_pix(input logic [8:0] row, input logic [9:0] col);
    return pix(int'(row) * DEC + VS0, int'(col) * DEC + HS0);
  endfunction

  int          wcount = 0, data_bad = 0, errs = 0, dones = 0;
  int          lock_cyc = -1, err_cyc = -1, done_cyc = -1;
  logic        locked_prev = 1'b0;
  logic [8:0]  wlog_row  [4096];
  logic [9:0]  wlog_col  [4096];
  logic [11:0] wlog_data [4096];
  int          wlog_cyc  [4096];

  always @(negedge clk) begin
    if (vid.wen === 1'b1) begin
      if (wcount < 4096) begin
        wlog_row[wcount]  <= vid.wr_row;
        wlog_col[wcount]  <= vid.wr_col;
        wlog_data[wcount] <= vid.wr_data;
        wlog_cyc[wcount]  <= cyc;
      end
      if (vid.wr_data !== exp_pix(vid.wr_row, vid.wr_col)) data_bad <= data_bad + 1;
      wcount <= wcount + 1;
    end
    if (vid.err === 1'b1) begin
      errs    <= errs + 1;
      err_cyc <= cyc;
    end
    if (vid.frame_done === 1'b1) begin
      dones    <= dones + 1;
      done_cyc <= cyc;
    end
    if (vid.locked === 1'b1 && locked_prev !== 1'b1) lock_cyc <= cyc;
    locked_prev <= vid.locked;
  end

  int n_total = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int mark_cyc = -1, abc_cyc = -1, last_cyc = -1;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      vid.hs = 1'b1;
      vid.vs = 1'b1;
      {vid.r, vid.g, vid.b} = 12'h000;
      @(posedge clk); #1;
    end
  endtask

  // hs low for 4 clocks at the start of each line, vs low for lines 0-1.
  task automatic drive_frame(input int nlines, input int short_l, input int mark_l,
                             input int stop_l, input int stop_h);
    for (int l = 0; l < nlines; l++) begin
      for (int h = 0; h < ((l == short_l) ? HT - 1 : HT); h++) begin
        if (l == stop_l && h == stop_h) return;
        vid.hs = (h >= 4);
        vid.vs = (l >= 2);
        {vid.r, vid.g, vid.b} = pix(l, h);
        if (l == mark_l && h == 0) mark_cyc = cyc;
        if (l == VS0 && h == HS0) abc_cyc = cyc;
        if (l == VS0 + VA - 1 && h == HS0 + HA - 1) last_cyc = cyc;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    int w0, e0, d0;
    vid.hs = 1'b1;
    vid.vs = 1'b1;
    {vid.r, vid.g, vid.b} = 12'h000;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wen",     32'(vid.wen), 0);
    check("rst_locked",  32'(vid.locked), 0);
    check("rst_err",     32'(vid.err), 0);
    check("rst_done",    32'(vid.frame_done), 0);
    check("rst_row",     32'(vid.wr_row), 0);
    check("rst_col",     32'(vid.wr_col), 0);
    check("rst_data",    32'(vid.wr_data), 0);
    rst = 1'b0;
    idle(5);

    w0 = wcount;
    drive_frame(VT, -1, -1, -1, -1);
    check("f1_locked", 32'(vid.locked), 0);
    check("f1_writes", wcount - w0, 0);

    w0 = wcount; d0 = dones; e0 = errs;
    drive_frame(VT, -1, 0, -1, -1);
    check("f2_lock_latency", lock_cyc - mark_cyc, 2);
    check("f2_locked",       32'(vid.locked), 1);
    check("f2_writes",       wcount - w0, FRAME_W);
    check("f2_done_count",   dones - d0, 1);
    check("f2_done_latency", done_cyc - last_cyc, 2);
    check("f2_errs",         errs - e0, 0);
    check("first_row",       32'(wlog_row[w0]), 0);
    check("first_col",       32'(wlog_col[w0]), 0);
    check("first_data",      32'(wlog_data[w0]), 32'h0ABC);
    check("abc_latency",     wlog_cyc[w0] - abc_cyc, 2);
    check("last_row",        32'(wlog_row[wcount - 1]), VA / DEC - 1);
    check("last_col",        32'(wlog_col[wcount - 1]), HA / DEC - 1);
    check("data_model",      data_bad, 0);

    w0 = wcount; d0 = dones; e0 = errs;
    drive_frame(VT, 6, 7, -1, -1);
    check("short_err_count",   errs - e0, 1);
    check("short_err_latency", err_cyc - mark_cyc, 2);
    check("short_locked",      32'(vid.locked), 0);
    check("short_writes",      wcount - w0, ((3 + DEC - 1) / DEC) * (HA / DEC));
    check("short_done",        dones - d0, 0);

    w0 = wcount;
    drive_frame(VT, -1, -1, -1, -1);
    check("remeasure_writes", wcount - w0, 0);
    check("remeasure_locked", 32'(vid.locked), 0);

    w0 = wcount;
    drive_frame(VT, -1, 0, -1, -1);
    check("relock_latency", lock_cyc - mark_cyc, 2);
    check("relock_writes",  wcount - w0, FRAME_W);

    w0 = wcount; e0 = errs;
    drive_frame(VT - 1, -1, -1, -1, -1);
    check("f19_errs_inside", errs - e0, 0);
    check("f19_writes",      wcount - w0, FRAME_W);
    check("f19_locked",      32'(vid.locked), 1);

    w0 = wcount; e0 = errs;
    drive_frame(VT, -1, 0, -1, -1);
    check("vs_err_count",   errs - e0, 1);
    check("vs_err_latency", err_cyc - mark_cyc, 2);
    check("vs_locked",      32'(vid.locked), 0);
    check("vs_writes",      wcount - w0, 0);

    drive_frame(VT, -1, -1, -1, -1);
    drive_frame(VT, -1, -1, 8, 20);
    check("pre_rst_locked", 32'(vid.locked), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_wen",    32'(vid.wen), 0);
    check("mid_rst_locked", 32'(vid.locked), 0);
    check("mid_rst_row",    32'(vid.wr_row), 0);
    check("mid_rst_col",    32'(vid.wr_col), 0);
    check("mid_rst_data",   32'(vid.wr_data), 0);
    check("mid_rst_err",    32'(vid.err), 0);
    check("mid_rst_done",   32'(vid.frame_done), 0);
    w0 = wcount;
    rst = 1'b0;
    idle(5);
    check("rst_abort_writes", wcount - w0, 0);

    w0 = wcount;
    drive_frame(VT, -1, -1, -1, -1);
    check("post_rst_measure_locked", 32'(vid.locked), 0);
    check("post_rst_measure_writes", wcount - w0, 0);

    w0 = wcount;
    drive_frame(VT, -1, 0, -1, -1);
    check("post_rst_lock_latency", lock_cyc - mark_cyc, 2);
    check("post_rst_writes",       wcount - w0, FRAME_W);
    check("post_rst_locked",       32'(vid.locked), 1);
    check("final_data_model",      data_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
